// File: rtl/sc_collatz_ctrl_pkg.sv
// Collatz controller shared definitions:
// datapath op codes, error codes and FSM states.
package sc_collatz_ctrl_pkg;

   localparam logic [1:0] OP_HOLD    = 2'b00;
   localparam logic [1:0] OP_LOAD    = 2'b01;
   localparam logic [1:0] OP_HALF    = 2'b10;
   localparam logic [1:0] OP_TRIPLE1 = 2'b11;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ZERO  = 2'b01;
   localparam logic [1:0] ERR_OVF   = 2'b10;
   localparam logic [1:0] ERR_LIMIT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_HALF  = 3'd3,
      ST_TRIP  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/sc_collatz_stepcnt.sv
// Iteration counter for the Collatz controller:
// sync clear, increment enable, at-limit flag.
module sc_collatz_stepcnt
   import sc_collatz_ctrl_pkg::*;
#(
   parameter int STEPWIDTH = 8,
   parameter int MAX_STEPS = 255
) (
   input  logic                 SC_COLLATZSTEPCNT_CLOCK_50,
   input  logic                 SC_COLLATZSTEPCNT_RESET_InLow,
   input  logic                 SC_COLLATZSTEPCNT_clear_In,
   input  logic                 SC_COLLATZSTEPCNT_inc_In,
   output logic [STEPWIDTH-1:0] SC_COLLATZSTEPCNT_count_OutBUS,
   output logic                 SC_COLLATZSTEPCNT_atLimit_Out
);

   localparam logic [STEPWIDTH-1:0] LIMIT = STEPWIDTH'(MAX_STEPS);

   logic [STEPWIDTH-1:0] countReg;

   // Clear wins over increment; the count saturates at the limit
   always_ff @(posedge SC_COLLATZSTEPCNT_CLOCK_50) begin
      if (!SC_COLLATZSTEPCNT_RESET_InLow) begin
         countReg <= '0;
      end else if (SC_COLLATZSTEPCNT_clear_In) begin
         countReg <= '0;
      end else if (SC_COLLATZSTEPCNT_inc_In && (countReg != LIMIT)) begin
         countReg <= countReg + STEPWIDTH'(1);
      end
   end

   assign SC_COLLATZSTEPCNT_count_OutBUS = countReg;
   assign SC_COLLATZSTEPCNT_atLimit_Out  = (countReg == LIMIT);

endmodule

// File: rtl/sc_collatz_ctrl.sv
// Collatz sequencing controller: issues one datapath
// op per step and reports done, error and step count.
module sc_collatz_ctrl
   import sc_collatz_ctrl_pkg::*;
#(
   parameter int STEPWIDTH = 8,
   parameter int MAX_STEPS = 255
) (
   input  logic                 SC_COLLATZCTRL_CLOCK_50,
   input  logic                 SC_COLLATZCTRL_RESET_InLow,
   input  logic                 SC_COLLATZCTRL_start_In,
   input  logic                 SC_COLLATZCTRL_abort_In,
   input  logic                 SC_COLLATZCTRL_zero_In,
   input  logic                 SC_COLLATZCTRL_one_In,
   input  logic                 SC_COLLATZCTRL_odd_In,
   input  logic                 SC_COLLATZCTRL_ovf_In,
   output logic [1:0]           SC_COLLATZCTRL_op_OutBUS,
   output logic                 SC_COLLATZCTRL_busy_Out,
   output logic                 SC_COLLATZCTRL_done_Out,
   output logic [1:0]           SC_COLLATZCTRL_err_OutBUS,
   output logic [STEPWIDTH-1:0] SC_COLLATZCTRL_steps_OutBUS
);

   state_t     state;
   logic [1:0] opReg;
   logic [1:0] errReg;
   logic       busyReg;
   logic       doneReg;
   logic       cntClear;
   logic       cntInc;
   logic       atLimit;
   logic       abortHit;

   assign abortHit = SC_COLLATZCTRL_abort_In && (state != ST_IDLE);
   assign cntClear = (state == ST_IDLE) && SC_COLLATZCTRL_start_In;
   assign cntInc   = ((state == ST_HALF) || (state == ST_TRIP))
                   && !SC_COLLATZCTRL_abort_In;

   sc_collatz_stepcnt #(
      .STEPWIDTH (STEPWIDTH),
      .MAX_STEPS (MAX_STEPS)
   ) u_stepcnt (
      .SC_COLLATZSTEPCNT_CLOCK_50     (SC_COLLATZCTRL_CLOCK_50),
      .SC_COLLATZSTEPCNT_RESET_InLow  (SC_COLLATZCTRL_RESET_InLow),
      .SC_COLLATZSTEPCNT_clear_In     (cntClear),
      .SC_COLLATZSTEPCNT_inc_In       (cntInc),
      .SC_COLLATZSTEPCNT_count_OutBUS (SC_COLLATZCTRL_steps_OutBUS),
      .SC_COLLATZSTEPCNT_atLimit_Out  (atLimit)
   );

   // Sequencing FSM; outputs are registered for the state being entered
   always_ff @(posedge SC_COLLATZCTRL_CLOCK_50) begin
      if (!SC_COLLATZCTRL_RESET_InLow) begin
         state   <= ST_IDLE;
         opReg   <= OP_HOLD;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
         errReg  <= ERR_OK;
      end else if (abortHit) begin
         state   <= ST_IDLE;
         opReg   <= OP_HOLD;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
         errReg  <= ERR_OK;
      end else begin
         doneReg <= 1'b0;
         opReg   <= OP_HOLD;
         unique case (state)
            ST_IDLE: begin
               if (SC_COLLATZCTRL_start_In) begin
                  state   <= ST_LOAD;
                  opReg   <= OP_LOAD;
                  busyReg <= 1'b1;
                  errReg  <= ERR_OK;
               end
            end
            ST_LOAD: begin
               state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (SC_COLLATZCTRL_ovf_In) begin
                  state   <= ST_DONE;
                  doneReg <= 1'b1;
                  errReg  <= ERR_OVF;
               end else if (SC_COLLATZCTRL_zero_In) begin
                  state   <= ST_DONE;
                  doneReg <= 1'b1;
                  errReg  <= ERR_ZERO;
               end else if (SC_COLLATZCTRL_one_In) begin
                  state   <= ST_DONE;
                  doneReg <= 1'b1;
                  errReg  <= ERR_OK;
               end else if (atLimit) begin
                  state   <= ST_DONE;
                  doneReg <= 1'b1;
                  errReg  <= ERR_LIMIT;
               end else if (SC_COLLATZCTRL_odd_In) begin
                  state <= ST_TRIP;
                  opReg <= OP_TRIPLE1;
               end else begin
                  state <= ST_HALF;
                  opReg <= OP_HALF;
               end
            end
            ST_HALF, ST_TRIP: begin
               state <= ST_CHECK;
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               busyReg <= 1'b0;
            end
            default: begin
               state   <= ST_IDLE;
               busyReg <= 1'b0;
            end
         endcase
      end
   end

   assign SC_COLLATZCTRL_op_OutBUS  = opReg;
   assign SC_COLLATZCTRL_busy_Out   = busyReg;
   assign SC_COLLATZCTRL_done_Out   = doneReg;
   assign SC_COLLATZCTRL_err_OutBUS = errReg;

endmodule

// File: tb/tb_sc_collatz_ctrl.sv
// Self-checking bench for sc_collatz_ctrl with an
// 8-bit behavioural datapath and a result scoreboard.
module tb_sc_collatz_ctrl;

   localparam logic [1:0] OPH = 2'b00;
   localparam logic [1:0] OPL = 2'b01;
   localparam logic [1:0] OPV = 2'b10;
   localparam logic [1:0] OPT = 2'b11;

   typedef struct {
      logic [1:0] err;
      int         steps;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       startLim = 1'b0;
   logic [1:0] op, opLim, err, errLim;
   logic       busy, busyLim, done, doneLim;
   logic [7:0] steps, stepsLim;
   logic [7:0] loadVal = 8'd0, loadLim = 8'd0;
   logic [7:0] val = 8'd0, valLim = 8'd0;
   logic       ovf = 1'b0, ovfLim = 1'b0;
   logic [9:0] tNext, tNextLim;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t doneQ[$];
   logic [1:0] opQ[$];
   logic [1:0] limOpQ[$];

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   sc_collatz_ctrl dut (
      .SC_COLLATZCTRL_CLOCK_50     (clk),
      .SC_COLLATZCTRL_RESET_InLow  (rstN),
      .SC_COLLATZCTRL_start_In     (start),
      .SC_COLLATZCTRL_abort_In     (abort),
      .SC_COLLATZCTRL_zero_In      (val == 8'd0),
      .SC_COLLATZCTRL_one_In       (val == 8'd1),
      .SC_COLLATZCTRL_odd_In       (val[0]),
      .SC_COLLATZCTRL_ovf_In       (ovf),
      .SC_COLLATZCTRL_op_OutBUS    (op),
      .SC_COLLATZCTRL_busy_Out     (busy),
      .SC_COLLATZCTRL_done_Out     (done),
      .SC_COLLATZCTRL_err_OutBUS   (err),
      .SC_COLLATZCTRL_steps_OutBUS (steps)
   );

   sc_collatz_ctrl #(.STEPWIDTH(8), .MAX_STEPS(5)) dutLim (
      .SC_COLLATZCTRL_CLOCK_50     (clk),
      .SC_COLLATZCTRL_RESET_InLow  (rstN),
      .SC_COLLATZCTRL_start_In     (startLim),
      .SC_COLLATZCTRL_abort_In     (1'b0),
      .SC_COLLATZCTRL_zero_In      (valLim == 8'd0),
      .SC_COLLATZCTRL_one_In       (valLim == 8'd1),
      .SC_COLLATZCTRL_odd_In       (valLim[0]),
      .SC_COLLATZCTRL_ovf_In       (ovfLim),
      .SC_COLLATZCTRL_op_OutBUS    (opLim),
      .SC_COLLATZCTRL_busy_Out     (busyLim),
      .SC_COLLATZCTRL_done_Out     (doneLim),
      .SC_COLLATZCTRL_err_OutBUS   (errLim),
      .SC_COLLATZCTRL_steps_OutBUS (stepsLim)
   );

   // 8-bit datapath models driven by the op buses
   assign tNext    = 10'(val) * 10'd3 + 10'd1;
   assign tNextLim = 10'(valLim) * 10'd3 + 10'd1;

   always @(posedge clk) begin
      case (op)
         OPL: begin val <= loadVal; ovf <= 1'b0; end
         OPV: begin val <= val >> 1; ovf <= 1'b0; end
         OPT: begin val <= tNext[7:0]; ovf <= (tNext > 10'd255); end
         default: ;
      endcase
      case (opLim)
         OPL: begin valLim <= loadLim; ovfLim <= 1'b0; end
         OPV: begin valLim <= valLim >> 1; ovfLim <= 1'b0; end
         OPT: begin valLim <= tNextLim[7:0]; ovfLim <= (tNextLim > 10'd255); end
         default: ;
      endcase
   end

   function automatic void pushOp(input bit toLim, input logic [1:0] o);
      if (toLim) limOpQ.push_back(o);
      else opQ.push_back(o);
   endfunction

   // Reference Collatz run: expected op trace, error and step count
   task automatic modelRun(input logic [7:0] v, input int maxS, input bit toLim,
                           output logic [1:0] e, output int s);
      logic [7:0] x;
      logic [9:0] t;
      bit         ov;
      x = v; ov = 1'b0; s = 0; e = 2'b00;
      pushOp(toLim, OPL);
      for (int i = 0; i < 1000; i++) begin
         pushOp(toLim, OPH);
         if (ov) begin e = 2'b10; break; end
         else if (x == 8'd0) begin e = 2'b01; break; end
         else if (x == 8'd1) begin e = 2'b00; break; end
         else if (s == maxS) begin e = 2'b11; break; end
         else if (x[0]) begin
            pushOp(toLim, OPT);
            t = 10'(x) * 10'd3 + 10'd1;
            ov = (t > 10'd255);
            x = t[7:0];
            s++;
         end else begin
            pushOp(toLim, OPV);
            x = x >> 1;
            ov = 1'b0;
            s++;
         end
      end
      pushOp(toLim, OPH);
   endtask

   // Scoreboard: compares op trace and done results of the main DUT
   always @(negedge clk) begin
      logic [1:0] eo;
      exp_t       ed;
      if (rstN) begin
         checks++;
         if (busy === 1'b1) begin
            if (opQ.size() == 0) begin
               failures++;
               $display("FAIL op_unexpected got=%0d cyc=%0d", op, cyc);
            end else begin
               eo = opQ.pop_front();
               if (op !== eo) begin
                  failures++;
                  $display("FAIL op_seq got=%0d want=%0d cyc=%0d", op, eo, cyc);
               end
            end
         end else if (op !== OPH) begin
            failures++;
            $display("FAIL op_idle got=%0d want=0 cyc=%0d", op, cyc);
         end
         if (done === 1'b1) begin
            checks++;
            if (doneQ.size() == 0) begin
               failures++;
               $display("FAIL done_unexpected cyc=%0d", cyc);
            end else begin
               ed = doneQ.pop_front();
               if (err !== ed.err || steps !== 8'(ed.steps) || cyc != ed.cyc) begin
                  failures++;
                  $display("FAIL done_result err=%0d/%0d steps=%0d/%0d cyc=%0d/%0d",
                           err, ed.err, steps, ed.steps, cyc, ed.cyc);
               end
            end
         end
      end
   end

   task automatic startRun(input logic [7:0] v, input bit withAbort);
      exp_t       ed;
      logic [1:0] e;
      int         s;
      @(negedge clk);
      modelRun(v, 255, 1'b0, e, s);
      ed.err = e;
      ed.steps = s;
      ed.cyc = cyc + 3 + 2 * s;
      doneQ.push_back(ed);
      loadVal = v;
      start = 1'b1;
      abort = withAbort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic waitDone(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 700 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout done=0 want=1", nm);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || opQ.size() != 0) begin
         failures++;
         $display("FAIL %s_after busy=%0d want=0 ops_left=%0d want=0",
                  nm, busy, opQ.size());
      end
   endtask

   task automatic checkIdle(input string nm, input logic [7:0] wantSteps);
      checks++;
      if (op !== OPH || busy !== 1'b0 || done !== 1'b0 ||
          err !== 2'b00 || steps !== wantSteps) begin
         failures++;
         $display("FAIL %s op=%0d busy=%0d done=%0d err=%0d steps=%0d want 0/0/0/0/%0d",
                  nm, op, busy, done, err, steps, wantSteps);
      end
   endtask

   task automatic test_reset;
      rstN = 1'b0;
      repeat (3) @(negedge clk);
      checkIdle("reset_state", 8'd0);
      checks++;
      if (opLim !== OPH || busyLim !== 1'b0 || doneLim !== 1'b0 ||
          errLim !== 2'b00 || stepsLim !== 8'd0) begin
         failures++;
         $display("FAIL reset_state_lim op=%0d busy=%0d steps=%0d want 0",
                  opLim, busyLim, stepsLim);
      end
      rstN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_value_one;
      startRun(8'd1, 1'b0);
      waitDone("value_one");
   endtask

   task automatic test_value_six;
      startRun(8'd6, 1'b0);
      waitDone("value_six");
   endtask

   task automatic test_value_zero;
      startRun(8'd0, 1'b0);
      waitDone("value_zero");
   endtask

   task automatic test_overflow;
      startRun(8'd27, 1'b0);
      waitDone("overflow");
      checks++;
      if (err !== 2'b10 || steps !== 8'd12) begin
         failures++;
         $display("FAIL overflow_hold err=%0d want=2 steps=%0d want=12", err, steps);
      end
   endtask

   task automatic test_step_limit;
      logic [1:0] e, eo;
      int         s;
      bit         seen = 1'b0;
      @(negedge clk);
      modelRun(8'd6, 5, 1'b1, e, s);
      loadLim = 8'd6;
      startLim = 1'b1;
      @(negedge clk);
      startLim = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         eo = (limOpQ.size() != 0) ? limOpQ.pop_front() : 2'bxx;
         if (busyLim !== 1'b1 || opLim !== eo) begin
            failures++;
            $display("FAIL limit_op got=%0d want=%0d busy=%0d", opLim, eo, busyLim);
         end
         if (doneLim === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (errLim !== e || stepsLim !== 8'(s)) begin
               failures++;
               $display("FAIL limit_result err=%0d want=%0d steps=%0d want=%0d",
                        errLim, e, stepsLim, s);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (!seen || busyLim !== 1'b0 || opLim !== OPH || limOpQ.size() != 0) begin
         failures++;
         $display("FAIL limit_end seen=%0d busy=%0d op=%0d want 1/0/0", seen, busyLim, opLim);
      end
   endtask

   task automatic test_abort;
      startRun(8'd27, 1'b0);
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      opQ.delete();
      doneQ.delete();
      @(negedge clk);
      abort = 1'b0;
      checkIdle("abort_idle", 8'd3);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
      checkIdle("abort_in_idle", 8'd3);
   endtask

   task automatic test_back_to_back;
      startRun(8'd6, 1'b1);
      repeat (4) @(negedge clk);
      loadVal = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone("busy_start");
      startRun(8'd7, 1'b0);
      waitDone("back_to_back");
   endtask

   task automatic test_reset_midrun;
      startRun(8'd27, 1'b0);
      repeat (5) @(negedge clk);
      rstN = 1'b0;
      @(posedge clk);
      opQ.delete();
      doneQ.delete();
      @(negedge clk);
      checkIdle("reset_midrun", 8'd0);
      rstN = 1'b1;
      startRun(8'd1, 1'b0);
      waitDone("after_reset");
   endtask

   initial begin
      test_reset();
      test_value_one();
      test_value_six();
      test_value_zero();
      test_overflow();
      test_step_limit();
      test_abort();
      test_back_to_back();
      test_reset_midrun();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sc_collatz_ctrl.md
Name: sc_collatz_ctrl

Overview:
- Sequencing controller for the Collatz datapath (working register, halver, 3n+1 unit).
- Takes a start request, issues one datapath operation per step and reads back the datapath status flags.
- Counts iterations and reports completion, step count and error code to the top level.
- Holds no data value itself; it only sequences the datapath registers.

Parameters:
- STEPWIDTH, 8, width of the step counter and of steps_OutBUS.
- MAX_STEPS, 255, step limit; reaching it without converging is an error. Must be at most 2^STEPWIDTH-1.

Ports:
- SC_COLLATZCTRL_CLOCK_50  in  1  single system clock, rising edge.
- SC_COLLATZCTRL_RESET_InLow  in  1  synchronous, active-low reset, sampled on the clock edge.
- SC_COLLATZCTRL_start_In  in  1  start request; sampled only in IDLE.
- SC_COLLATZCTRL_abort_In  in  1  abandon the current run.
- SC_COLLATZCTRL_zero_In  in  1  datapath value == 0.
- SC_COLLATZCTRL_one_In  in  1  datapath value == 1.
- SC_COLLATZCTRL_odd_In  in  1  datapath value bit0.
- SC_COLLATZCTRL_ovf_In  in  1  last 3n+1 overflowed the datapath width.
- SC_COLLATZCTRL_op_OutBUS  out  2  datapath operation: 00 HOLD, 01 LOAD, 10 HALF, 11 TRIPLE1.
- SC_COLLATZCTRL_busy_Out  out  1  high in every state except IDLE.
- SC_COLLATZCTRL_done_Out  out  1  one-cycle pulse at the end of a run (success or error).
- SC_COLLATZCTRL_err_OutBUS  out  2  00 ok, 01 zero input, 10 overflow, 11 step limit.
- SC_COLLATZCTRL_steps_OutBUS  out  STEPWIDTH  iterations performed.

Behaviour:
- Reset: RESET_InLow=0 at a clock edge puts the FSM in IDLE, op=HOLD, busy=0, done=0, err=00, steps=0. This applies from any state, mid-run included.
- Outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- States: IDLE, LOAD, CHECK, HALF, TRIP, DONE.
- IDLE: op=HOLD.
  - start=1 → LOAD; steps cleared to 0 and err cleared to 00 on the same edge.
- LOAD: op=LOAD for exactly one cycle → CHECK.
- CHECK: op=HOLD. Status flags reflect the value written by the previous op. Evaluation priority:
  - ovf → DONE with err=10.
  - zero → DONE with err=01.
  - one → DONE with err=00.
  - steps==MAX_STEPS → DONE with err=11.
  - odd → TRIP.
  - otherwise → HALF.
- HALF / TRIP: op=10 / 11 for one cycle; steps increments on the same edge → CHECK.
  - Each iteration costs 2 cycles.
- DONE: done=1 for one cycle, op=HOLD → IDLE.
  - err and steps hold their values until the next accepted start.
- Latency: start sampled at edge k gives LOAD in cycle k+1 and first CHECK in k+2.
  - Value 1: done is high in cycle k+3.
  - General case: done in cycle k+3+2·steps.
- The counter never wraps: the MAX_STEPS check precedes any increment, so steps ≤ MAX_STEPS.
- start while busy is ignored; it is not queued.
- abort=1 in any non-IDLE state (DONE included) → IDLE on the next edge.
  - No done pulse; err=00; steps keep the partial count.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Reset has priority over abort and start.

Decomposition:
- Shared package holds:
  - op encodings OP_HOLD/OP_LOAD/OP_HALF/OP_TRIPLE1;
  - error codes ERR_OK/ERR_ZERO/ERR_OVF/ERR_LIMIT;
  - the state encoding constants.
- One natural sub-module, sc_collatz_stepcnt: STEPWIDTH counter with synchronous clear, increment enable and an at-limit compare output.
- FSM and output decode stay in the top module.

Test Plan:
- Datapath model loaded with 1, pulse start → op sequence LOAD, HOLD; done pulses in cycle k+3; steps=0, err=00.
- Value 6 → ops LOAD, HALF, TRIP, HALF, TRIP, HALF, HALF, HALF, HALF with HOLD (CHECK) cycles between each; done in cycle k+19; steps=8, err=00.
- Value 0 → single CHECK then done; err=01, steps=0.
- Value 27 with an 8-bit model → overflow on 107→322; err=10, steps=12; busy low the cycle after done.
- MAX_STEPS=5, value 6 → done with err=11, steps=5; no sixth op is issued.
- Value 27 with abort asserted after 3 steps → IDLE next edge, no done, steps=3. A second run is started and, mid-run, start is pulsed while busy: the pulse is ignored. RESET_InLow is then taken low mid-run: all outputs are 0 on the next edge.
